// File: rtl/seven_seg_scanner.sv
// 4-digit multiplexed 7-segment scanner: frame-buffered hex decode, leading-zero blanking,
// anti-ghost slot blanking and 8-level brightness; all outputs registered.
module seven_seg_scanner #(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] display_in,
  input  logic [2:0]  brightness,
  input  logic        lamp_test,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] LAST    = PW'(REFRESH_DIV - 1);
  localparam logic [31:0]   BLANK_U = 32'(BLANK_CYCLES);
  localparam logic [31:0]   SPAN_U  = 32'(REFRESH_DIV - BLANK_CYCLES);
  localparam logic [6:0]    SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]    AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [PW-1:0] presc;
  logic [1:0]    digit;
  logic [15:0]   shadow;
  logic [2:0]    bright_q;

  logic          end_slot;
  logic [15:0]   upper;
  logic [3:0]    nib;
  logic          blanked;
  logic [31:0]   presc_ext;
  logic [31:0]   on_len;
  logic          lit;
  logic [3:0]    onehot;
  logic [6:0]    pattern;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  always_comb begin
    end_slot  = (presc == LAST);
    // Nibbles digit..3 shifted down; all-zero means this digit is a leading zero.
    upper     = shadow >> {digit, 2'b00};
    nib       = upper[3:0];
    blanked   = BLANK_LEADING && (digit != 2'd0) && (upper == 16'h0);
    presc_ext = 32'(presc);
    on_len    = (SPAN_U * (32'(bright_q) + 32'd1)) >> 3;
    if (lamp_test)
      lit = (presc_ext >= BLANK_U);
    else
      lit = !blanked && (presc_ext >= BLANK_U) && (presc_ext < BLANK_U + on_len);
    onehot  = 4'b0001 << digit;
    pattern = lamp_test ? 7'h7F : hex_decode(nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      digit      <= 2'd0;
      shadow     <= 16'h0;
      bright_q   <= 3'd0;
      frame_tick <= 1'b0;
      seg        <= SEG_OFF;
      an         <= AN_OFF;
    end else begin
      presc <= end_slot ? '0 : presc + 1'b1;
      if (end_slot)
        digit <= digit + 2'd1;
      // Frame boundary: latch the new word and brightness together so nothing tears.
      if (end_slot && digit == 2'd3) begin
        shadow   <= display_in;
        bright_q <= brightness;
      end
      frame_tick <= end_slot && (digit == 2'd3);
      seg        <= SEG_ACTIVE_LOW ? ~pattern : pattern;
      if (lit)
        an <= AN_ACTIVE_LOW ? ~onehot : onehot;
      else
        an <= AN_OFF;
    end
  end

endmodule
